spi_pack_tx: RTL and testbench
==============================

# spi_pack_tx

Serial packet transmitter for the command link: the sending end of the `spi_sclk`/`spi_din` two-wire stream that the command depacketizer receives. It frames a fixed-length payload as header, payload and CRC-16, and shifts it out MSB-first with a generated serial clock. It is used as the host-side/loopback source in bench and board bring-up, and as the building block for a future status-return link. There is no chip-select line; the receiver resynchronises on the header, and an idle gap separates frames.

## Interface
- `PAYLOAD_BYTES`, 36 — payload bytes per frame (1..255).
- `CLK_DIV`, 4 — `spi_sclk` half-period in `clk` cycles (≥1).
- `GAP_BITS`, 16 — idle bit-periods after the CRC, with `spi_sclk` held low.
- `HDR0`, 8'hEB — first header byte.
- `HDR1`, 8'h90 — second header byte.

Ports:
- `clk` in 1 — system clock; the only clock.
- `rst` in 1 — reset. Synchronous, active-high.
- `start` in 1 — single-cycle request to send one frame. Ignored while `busy`=1.
- `s_data` in 8 — payload byte.
- `s_valid` in 1 — `s_data` is valid.
- `s_ready` out 1 — the block is taking a payload byte. A transfer happens when `s_valid`&&`s_ready`.
- `busy` out 1 — a frame (including its gap) is in progress.
- `done` out 1 — one-cycle pulse at the end of the frame.
- `crc_out` out 16 — CRC of the last completed frame.
- `spi_sclk` out 1 — serial clock; idle low.
- `spi_din` out 1 — serial data; changes only while `spi_sclk` is low; idle low.

## Operation
- **Frame order:** `HDR0`, `HDR1`, then `PAYLOAD_BYTES` payload bytes, then CRC[15:8], then CRC[7:0]. Every byte is sent MSB-first.
- **CRC:** CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no final XOR).
  - Computed over payload bytes only.
  - Updated byte-wise at each accepted transfer.
  - Reset to 0xFFFF at `start`.
- **States:** IDLE, LOAD, SHIFT, GAP, DONE.
- **IDLE:** `spi_sclk`=0, `spi_din`=0, `busy`=0. On `start`: clear the byte counter, init the CRC, go to LOAD.
- **LOAD** (one or more cycles, `spi_sclk`=0, `spi_din` holds its previous value):
  - Header and CRC bytes load unconditionally in 1 cycle.
  - Payload bytes: `s_ready`=1. The block stays in LOAD (stall) until `s_valid`. No timeout and no abort; the stall is invisible to the receiver because `spi_sclk` stops.
  - On load: shifter ← byte, bit counter ← 7, go to SHIFT.
- **SHIFT:** per bit, `spi_din`=shifter[7] for the whole bit period, `spi_sclk` low for `CLK_DIV` cycles then high for `CLK_DIV` cycles. The receiver samples on the rising edge. After bit 0's high phase:
  - more bytes remain → LOAD;
  - otherwise → GAP.
- **GAP:** `spi_sclk`=0 and `spi_din`=0 for `GAP_BITS`·2·`CLK_DIV` cycles, then DONE.
- **DONE:** one cycle with `done`=1 and `crc_out` updated, then IDLE (`busy`=0 in the same cycle as `done`).
- **Boundary conditions:**
  - `start` while busy: ignored, with no effect on the current frame.
  - `start` in the DONE cycle: ignored; it is accepted from IDLE only.
  - `s_valid` outside LOAD: ignored, and no byte is consumed.
  - `rst` mid-frame: next cycle all outputs are at reset values. A partial frame is abandoned; the receiver discards it via header/CRC.
- **Reset values:** `spi_sclk`=0, `spi_din`=0, `s_ready`=0, `busy`=0, `done`=0, `crc_out`=16'h0000, state IDLE.

## Timing
- **Start latency:** `start` sampled at edge k → `busy`=1 and LOAD at k+1. The first `spi_din` bit (`HDR0`[7]) is valid from k+2, and the first `spi_sclk` rise is at k+2+`CLK_DIV`.
- **Byte time** without stall: 1 + 16·`CLK_DIV` cycles.
- **Total `busy` time** without stall: (`PAYLOAD_BYTES`+4)·(1+16·`CLK_DIV`) + `GAP_BITS`·2·`CLK_DIV` + 1 cycles (the final +1 is the DONE cycle).
- **Stall cost:** each payload stall cycle adds exactly one cycle, spent with `spi_sclk` low.
- **`spi_din` transitions** happen only in LOAD→SHIFT and in the cycle `spi_sclk` falls; never while `spi_sclk`=1.
- **`s_ready` / `s_data`:** `s_ready` is registered. `s_data` is captured on the handshake edge.

## Test plan
- **CRC vector:** `PAYLOAD_BYTES`=9, `CLK_DIV`=2, payload 0x31..0x39 streamed with `s_valid` always high → serial capture on `spi_sclk` rise reads EB 90 31..39 29 B1; `crc_out`=16'h29B1 on `done`; `busy` lasts 13·33+64+1=494 cycles.
- **Source stall:** same frame, `s_valid` dropped for 10 cycles before the 5th payload byte → identical serial bytes, `spi_sclk` low throughout the stall, `busy` lasts 504 cycles.
- **Start while busy:** second `start` pulses at mid-payload and in the DONE cycle → exactly one frame sent, exactly one `done`.
- **Reset mid-frame:** assert `rst` during the 3rd payload byte → next cycle `spi_sclk`=0, `spi_din`=0, `busy`=0, `s_ready`=0, `crc_out`=0; a following `start` sends a clean full frame.
- **Loopback:** `PAYLOAD_BYTES`=36, random payload, serial lines fed to the command depacketizer → depacketizer ready with CRC error 0 and field values matching the payload bytes; a corrupted CRC byte forced at the serial line → depacketizer CRC error 1.
- **Divider edge case:** `CLK_DIV`=1, `GAP_BITS`=0 → `spi_sclk` toggles every cycle within a byte, `done` one cycle after the last high phase, with no glitch on `spi_din` while `spi_sclk`=1 (assertion).

Source files
------------

// File: rtl/spi_pack_tx.sv
// spi_pack_tx -- serial packet transmitter for the command link.
//
// Frames PAYLOAD_BYTES payload bytes as HDR0, HDR1, payload, CRC[15:8],
// CRC[7:0] and shifts every byte out MSB-first on spi_din, with a generated
// serial clock on spi_sclk. The receiver samples on the rising edge of
// spi_sclk. After the CRC, both lines stay low for an idle gap.
//
// Ports:
//   clk      in   system clock (only clock)
//   rst      in   synchronous active-high reset
//   start    in   single-cycle frame request, honoured only while idle
//   s_data   in   payload byte
//   s_valid  in   s_data is valid
//   s_ready  out  payload byte is being taken (transfer = s_valid && s_ready)
//   busy     out  frame (including gap) in progress
//   done     out  one-cycle end-of-frame pulse
//   crc_out  out  CRC-16/CCITT-FALSE of the last completed frame
//   spi_sclk out  serial clock, idle low
//   spi_din  out  serial data, changes only while spi_sclk is low
module spi_pack_tx #(
  parameter int unsigned PAYLOAD_BYTES = 36,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned GAP_BITS      = 16,
  parameter logic [7:0]  HDR0          = 8'hEB,
  parameter logic [7:0]  HDR1          = 8'h90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_out,
  output logic        spi_sclk,
  output logic        spi_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  // byte_idx counts bytes already loaded into the shifter in this frame.
  // Indices 0/1 are the header, 2..PAYLOAD_BYTES+1 the payload, then CRC.
  localparam logic [8:0]  CRC_HI_IDX = 9'(PAYLOAD_BYTES + 2);
  localparam logic [8:0]  CRC_LO_IDX = 9'(PAYLOAD_BYTES + 3);
  localparam logic [8:0]  LAST_IDX   = 9'(PAYLOAD_BYTES + 4);
  localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
  localparam logic [31:0] GAP_CYC    = 32'(GAP_BITS * 2 * CLK_DIV);

  state_t      state_q, state_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic        phase_q, phase_d;       // 0: sclk low half, 1: sclk high half
  logic [7:0]  shift_q, shift_d;
  logic [31:0] gap_q, gap_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] crc_out_q, crc_out_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  logic        load_fire, pay_fire, half_end, byte_end, gap_end;
  logic [7:0]  load_byte;

  // Byte-wise CRC-16/CCITT-FALSE update (poly 0x1021, MSB first).
  function automatic logic [15:0] crc16_byte(input logic [15:0] c_in,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic is_payload(input logic [8:0] idx);
    return (idx >= 9'd2) && (idx < CRC_HI_IDX);
  endfunction

  // In LOAD, ready_q is high exactly when the next byte is payload, so a
  // header/CRC byte loads unconditionally and a payload byte waits for s_valid.
  assign pay_fire  = (state_q == S_LOAD) && ready_q && s_valid;
  assign load_fire = (state_q == S_LOAD) && (!ready_q || s_valid);
  assign half_end  = (state_q == S_SHIFT) && (div_q == DIV_LAST);
  assign byte_end  = half_end && phase_q && (bit_q == 3'd0);
  assign gap_end   = (state_q == S_GAP) && (gap_q == GAP_CYC - 32'd1);

  always_comb begin
    if (byte_idx_q == 9'd0)           load_byte = HDR0;
    else if (byte_idx_q == 9'd1)      load_byte = HDR1;
    else if (byte_idx_q == CRC_HI_IDX) load_byte = crc_q[15:8];
    else if (byte_idx_q == CRC_LO_IDX) load_byte = crc_q[7:0];
    else                              load_byte = s_data;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      shift_q    <= '0;
      gap_q      <= '0;
      crc_q      <= 16'hFFFF;
      crc_out_q  <= 16'h0000;
      sclk_q     <= 1'b0;
      din_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      gap_q      <= gap_d;
      crc_q      <= crc_d;
      crc_out_q  <= crc_out_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (load_fire) state_d = S_SHIFT;
      S_SHIFT: begin
        if (byte_end) begin
          if (byte_idx_q != LAST_IDX) state_d = S_LOAD;
          else if (GAP_CYC == 32'd0)  state_d = S_DONE;
          else                        state_d = S_GAP;
        end
      end
      S_GAP:   if (gap_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    byte_idx_d = byte_idx_q;
    bit_d      = bit_q;
    div_d      = div_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    gap_d      = gap_q;
    crc_d      = crc_q;
    crc_out_d  = crc_out_q;
    din_d      = din_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          byte_idx_d = '0;
          crc_d      = 16'hFFFF;
        end
      end
      S_LOAD: begin
        if (load_fire) begin
          shift_d    = load_byte;
          bit_d      = 3'd7;
          div_d      = '0;
          phase_d    = 1'b0;
          din_d      = load_byte[7];
          byte_idx_d = byte_idx_q + 9'd1;
          if (pay_fire) crc_d = crc16_byte(crc_q, s_data);
        end
      end
      S_SHIFT: begin
        gap_d = '0;
        if (half_end) begin
          div_d   = '0;
          phase_d = ~phase_q;
          // Next bit appears on the same edge sclk falls; bit 0 is held
          // through LOAD until the next byte is loaded.
          if (phase_q && (bit_q != 3'd0)) begin
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            din_d   = shift_q[6];
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      S_GAP:   gap_d = gap_q + 32'd1;
      default: ;
    endcase

    if (state_d == S_IDLE || state_d == S_GAP || state_d == S_DONE) din_d = 1'b0;
    if (state_d == S_DONE) crc_out_d = crc_q;

    sclk_d  = (state_d == S_SHIFT) && phase_d;
    busy_d  = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_LOAD) && is_payload(byte_idx_d);
  end

  assign s_ready  = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign crc_out  = crc_out_q;
  assign spi_sclk = sclk_q;
  assign spi_din  = din_q;

endmodule

// File: tb/tb_spi_pack_tx.sv
`timescale 1ns/1ps
module tb_spi_pack_tx;

  localparam int PA = 9;
  localparam int PB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_start, a_valid, a_ready, a_busy, a_done, a_sclk, a_din;
  logic [7:0] a_data;
  logic [15:0] a_crc_out;
  logic b_start, b_valid, b_ready, b_busy, b_done, b_sclk, b_din;
  logic [7:0] b_data;
  logic [15:0] b_crc_out;

  spi_pack_tx #(.PAYLOAD_BYTES(PA), .CLK_DIV(2), .GAP_BITS(16),
                .HDR0(8'hEB), .HDR1(8'h90)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .s_data(a_data),
    .s_valid(a_valid), .s_ready(a_ready), .busy(a_busy), .done(a_done),
    .crc_out(a_crc_out), .spi_sclk(a_sclk), .spi_din(a_din)
  );

  spi_pack_tx #(.PAYLOAD_BYTES(PB), .CLK_DIV(1), .GAP_BITS(0),
                .HDR0(8'hEB), .HDR1(8'h90)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .s_data(b_data),
    .s_valid(b_valid), .s_ready(b_ready), .busy(b_busy), .done(b_done),
    .crc_out(b_crc_out), .spi_sclk(b_sclk), .spi_din(b_din)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-16/CCITT-FALSE.
  function automatic logic [15:0] crc_ref(input logic [7:0] q[$]);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[n]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ q[n][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  logic [7:0] payA[$];
  logic [7:0] payB[$];
  logic [7:0] expA[$];
  logic [7:0] expB[$];

  // Serial monitors: assemble bytes on sclk rise, compare against scoreboard.
  logic a_sclk_p = 1'b0, a_din_p = 1'b0;
  logic [7:0] a_sh = '0;
  int a_bits = 0, a_cyc = 0, a_done_cnt = 0, a_glitch = 0, a_stall_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      a_bits = 0;
    end else begin
      if (a_sclk && !a_sclk_p) begin
        a_sh = {a_sh[6:0], a_din};
        a_bits++;
        if (a_bits == 8) begin
          a_bits = 0;
          total++;
          assert (expA.size() > 0) else begin
            bad++;
            $error("FAIL A_extra_byte observed=%0h expected=none", a_sh);
          end
          if (expA.size() > 0) chk("A_byte", a_sh, expA.pop_front());
        end
      end
      if (a_sclk && (a_din !== a_din_p)) a_glitch++;
      if (a_busy || a_done) a_cyc++;
      if (a_done) a_done_cnt++;
    end
    a_sclk_p = a_sclk;
    a_din_p  = a_din;
  end

  logic b_sclk_p = 1'b0, b_din_p = 1'b0;
  logic [7:0] b_sh = '0;
  int b_bits = 0, b_cyc = 0, b_rises = 0, b_glitch = 0;

  always @(negedge clk) begin
    if (rst) begin
      b_bits = 0;
    end else begin
      if (b_sclk && !b_sclk_p) begin
        b_rises++;
        b_sh = {b_sh[6:0], b_din};
        b_bits++;
        if (b_bits == 8) begin
          b_bits = 0;
          total++;
          assert (expB.size() > 0) else begin
            bad++;
            $error("FAIL B_extra_byte observed=%0h expected=none", b_sh);
          end
          if (expB.size() > 0) chk("B_byte", b_sh, expB.pop_front());
        end
      end
      if (b_sclk && (b_din !== b_din_p)) b_glitch++;
      if (b_busy || b_done) b_cyc++;
      if (b_done) chk("B_done_after_high", b_sclk_p, 1);
    end
    b_sclk_p = b_sclk;
    b_din_p  = b_din;
  end

  // One frame on dut_a, inputs driven at negedge for the following posedge.
  task automatic run_a(input int stall_idx, input int stall_len, input int mid_start,
                       input int rst_at, input bit done_start,
                       output int cyc, output int dones, output logic [15:0] crc_seen);
    logic [15:0] rc;
    int i, sc;
    bit got, ms_on, ms_used, was_rst;
    rc = crc_ref(payA);
    expA.push_back(8'hEB);
    expA.push_back(8'h90);
    foreach (payA[k]) expA.push_back(payA[k]);
    expA.push_back(rc[15:8]);
    expA.push_back(rc[7:0]);
    a_cyc = 0; a_done_cnt = 0; a_stall_bad = 0; crc_seen = '0;
    i = 0; sc = 0; got = 0; ms_on = 0; ms_used = 0; was_rst = 0;
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (a_done) begin
        got = 1; crc_seen = a_crc_out;
        if (done_start) a_start = 1'b1;
        break;
      end
      if (ms_on) begin a_start = 1'b0; ms_on = 0; end
      if (rst_at >= 0 && i == rst_at) begin
        a_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("R_sclk", a_sclk, 0);
        chk("R_din", a_din, 0);
        chk("R_busy", a_busy, 0);
        chk("R_ready", a_ready, 0);
        chk("R_done", a_done, 0);
        chk("R_crc_out", a_crc_out, 0);
        rst = 1'b0;
        expA.delete();
        was_rst = 1;
        break;
      end
      if (i < PA) begin
        if (a_ready && i == stall_idx && sc < stall_len) begin
          a_valid = 1'b0; sc++;
          if (a_sclk) a_stall_bad++;
        end else begin
          a_valid = 1'b1; a_data = payA[i];
          if (a_ready) i++;
        end
      end else begin
        a_valid = 1'b0;
      end
      if (mid_start >= 0 && i == mid_start && !ms_used) begin
        a_start = 1'b1; ms_on = 1; ms_used = 1;
      end
      @(negedge clk);
    end
    @(negedge clk);
    a_start = 1'b0; a_valid = 1'b0;
    if (!was_rst) chk("A_done_seen", got, 1);
    repeat (3) @(negedge clk);
    cyc = a_cyc; dones = a_done_cnt;
  endtask

  task automatic rand_pay();
    payA.delete();
    for (int k = 0; k < PA; k++) payA.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, dn, j;
    bit got;
    logic [15:0] crc;
    rst = 1'b1;
    a_start = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_data = '0;
    repeat (3) @(negedge clk);
    chk("RST_sclk", a_sclk, 0);
    chk("RST_din", a_din, 0);
    chk("RST_ready", a_ready, 0);
    chk("RST_busy", a_busy, 0);
    chk("RST_done", a_done, 0);
    chk("RST_crc_out", a_crc_out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CRC vector "123456789"
    payA.delete();
    for (int k = 0; k < PA; k++) payA.push_back(8'h31 + 8'(k));
    run_a(-1, 0, -1, -1, 0, cyc, dn, crc);
    $display("frame vec: crc=%h busy_cycles=%0d dones=%0d", crc, cyc, dn);
    chk("VEC_crc", crc, 16'h29B1);
    chk("VEC_busy_len", cyc, 494);
    chk("VEC_done_cnt", dn, 1);
    chk("VEC_bytes_left", expA.size(), 0);
    chk("VEC_crc_hold", a_crc_out, 16'h29B1);

    // Source stall of 10 cycles before the 5th payload byte
    run_a(4, 10, -1, -1, 0, cyc, dn, crc);
    $display("frame stall: crc=%h busy_cycles=%0d", crc, cyc);
    chk("STALL_crc", crc, 16'h29B1);
    chk("STALL_busy_len", cyc, 504);
    chk("STALL_sclk_low", a_stall_bad, 0);
    chk("STALL_bytes_left", expA.size(), 0);

    // start mid-payload and in the DONE cycle
    rand_pay();
    run_a(-1, 0, 5, -1, 1, cyc, dn, crc);
    $display("frame start-busy: crc=%h busy_cycles=%0d dones=%0d", crc, cyc, dn);
    chk("SB_done_cnt", dn, 1);
    chk("SB_busy_len", cyc, 494);
    chk("SB_crc", crc, crc_ref(payA));
    chk("SB_bytes_left", expA.size(), 0);
    chk("SB_idle_after", a_busy, 0);

    // Reset during the 3rd payload byte, then a clean frame
    rand_pay();
    run_a(-1, 0, -1, 3, 0, cyc, dn, crc);
    $display("frame reset-mid: dones=%0d", dn);
    chk("RM_no_done", dn, 0);
    rand_pay();
    run_a(-1, 0, -1, -1, 0, cyc, dn, crc);
    $display("frame after-reset: crc=%h busy_cycles=%0d", crc, cyc);
    chk("AR_crc", crc, crc_ref(payA));
    chk("AR_busy_len", cyc, 494);
    chk("AR_bytes_left", expA.size(), 0);
    chk("A_din_glitch", a_glitch, 0);

    // CLK_DIV=1, GAP_BITS=0
    payB.delete();
    payB.push_back(8'hA5);
    payB.push_back(8'h3C);
    crc = crc_ref(payB);
    expB.push_back(8'hEB); expB.push_back(8'h90);
    expB.push_back(8'hA5); expB.push_back(8'h3C);
    expB.push_back(crc[15:8]); expB.push_back(crc[7:0]);
    b_cyc = 0; b_rises = 0; got = 0; j = 0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (b_done) begin got = 1; chk("B_crc", b_crc_out, crc); break; end
      if (j < PB) begin
        b_valid = 1'b1; b_data = payB[j];
        if (b_ready) j++;
      end else begin
        b_valid = 1'b0;
      end
      @(negedge clk);
    end
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("frame div1: busy_cycles=%0d rises=%0d", b_cyc, b_rises);
    chk("B_done_seen", got, 1);
    chk("B_busy_len", b_cyc, 103);
    chk("B_rises", b_rises, 48);
    chk("B_bytes_left", expB.size(), 0);
    chk("B_din_glitch", b_glitch, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
